// File: rtl/gray_counter_n.sv
// Parametrised synchronous Gray-code up/down counter with load, wrap/saturate
// terminal behaviour, binary mirror output and registered terminal-count flag.
module gray_counter_n #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_gray,
    output logic [WIDTH-1:0] q_bin,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;

    logic [WIDTH-1:0] bin_reg;
    logic [WIDTH-1:0] gray_reg;
    logic             tc_reg;
    logic [WIDTH-1:0] bin_next;
    logic             tc_next;

    always_comb begin
        bin_next = bin_reg;
        tc_next  = 1'b0;
        if (load) begin
            bin_next = load_val;
        end else if (en) begin
            if (up) begin
                if (bin_reg == MAX_VAL) begin
                    tc_next  = 1'b1;
                    bin_next = (SATURATE != 0) ? MAX_VAL : '0;
                end else begin
                    bin_next = bin_reg + 1'b1;
                end
            end else begin
                if (bin_reg == '0) begin
                    tc_next  = 1'b1;
                    bin_next = (SATURATE != 0) ? '0 : MAX_VAL;
                end else begin
                    bin_next = bin_reg - 1'b1;
                end
            end
        end
    end

    // Gray register is encoded from the next binary value so both update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg  <= RST_BIN;
            gray_reg <= RST_GRAY;
            tc_reg   <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= bin_next ^ (bin_next >> 1);
            tc_reg   <= tc_next;
        end
    end

    assign q_bin  = bin_reg;
    assign q_gray = gray_reg;
    assign tc     = tc_reg;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed bench for gray_counter_n: four instances cover wrap, saturate,
// load/reset priority and per-cycle direction changes.
module tb_gray_counter_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // A: WIDTH=4 wrap, RESET_VAL=0
    logic       rst_a, en_a, up_a, load_a, tc_a;
    logic [3:0] lv_a, g_a, b_a;
    // B: WIDTH=4 saturate
    logic       rst_b, en_b, up_b, load_b, tc_b;
    logic [3:0] lv_b, g_b, b_b;
    // C: WIDTH=8, RESET_VAL=3
    logic       rst_c, en_c, up_c, load_c, tc_c;
    logic [7:0] lv_c, g_c, b_c;
    // D: WIDTH=6 wrap
    logic       rst_d, en_d, up_d, load_d, tc_d;
    logic [5:0] lv_d, g_d, b_d;

    gray_counter_n #(.WIDTH(4), .SATURATE(0), .RESET_VAL(0)) u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .up(up_a), .load(load_a),
        .load_val(lv_a), .q_gray(g_a), .q_bin(b_a), .tc(tc_a));
    gray_counter_n #(.WIDTH(4), .SATURATE(1), .RESET_VAL(0)) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .up(up_b), .load(load_b),
        .load_val(lv_b), .q_gray(g_b), .q_bin(b_b), .tc(tc_b));
    gray_counter_n #(.WIDTH(8), .SATURATE(0), .RESET_VAL(3)) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .up(up_c), .load(load_c),
        .load_val(lv_c), .q_gray(g_c), .q_bin(b_c), .tc(tc_c));
    gray_counter_n #(.WIDTH(6), .SATURATE(0), .RESET_VAL(0)) u_d (
        .clk(clk), .rst(rst_d), .en(en_d), .up(up_d), .load(load_d),
        .load_val(lv_d), .q_gray(g_d), .q_bin(b_d), .tc(tc_d));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after a rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gray4_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                   4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                   4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                   4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [3:0] sat_bin [4] = '{4'd15, 4'd15, 4'd15, 4'd15};
    logic       sat_tc  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] prev4;

    initial begin
        {rst_a, en_a, up_a, load_a, lv_a} = '0;
        {rst_b, en_b, up_b, load_b, lv_b} = '0;
        {rst_c, en_c, up_c, load_c, lv_c} = '0;
        {rst_d, en_d, up_d, load_d, lv_d} = '0;
        #1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
        step();
        step();
        check("rst_a_bin", 16'(b_a), 16'd0);
        check("rst_a_gray", 16'(g_a), 16'd0);
        check("rst_a_tc", 16'(tc_a), 16'd0);
        check("rst_c_bin", 16'(b_c), 16'd3);
        check("rst_c_gray", 16'(g_c), 16'h02);
        check("rst_c_tc", 16'(tc_c), 16'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

        // 1: full up-count cycle through the 4-bit Gray sequence
        en_a = 1'b1; up_a = 1'b1;
        prev4 = g_a;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("t1_gray_%0d", i), 16'(g_a), 16'(gray4_tab[i % 16]));
            check($sformatf("t1_bin_%0d", i), 16'(b_a), 16'(i % 16));
            check($sformatf("t1_tc_%0d", i), 16'(tc_a), (i == 16) ? 16'd1 : 16'd0);
            check($sformatf("t1_hd_%0d", i), 16'($countones(prev4 ^ g_a)), 16'd1);
            prev4 = g_a;
        end

        // 2: load 0 then count down across the wrap
        en_a = 1'b0; load_a = 1'b1; lv_a = 4'd0;
        step();
        check("t2_load_bin", 16'(b_a), 16'd0);
        check("t2_load_tc", 16'(tc_a), 16'd0);
        load_a = 1'b0; en_a = 1'b1; up_a = 1'b0;
        step();
        check("t2_bin_15", 16'(b_a), 16'd15);
        check("t2_gray_15", 16'(g_a), 16'b1000);
        check("t2_tc_15", 16'(tc_a), 16'd1);
        step();
        check("t2_bin_14", 16'(b_a), 16'd14);
        check("t2_gray_14", 16'(g_a), 16'b1001);
        check("t2_tc_14", 16'(tc_a), 16'd0);
        en_a = 1'b0;

        // 3: saturate at max, then step down
        load_b = 1'b1; lv_b = 4'd14;
        step();
        check("t3_load_bin", 16'(b_b), 16'd14);
        load_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t3_bin_%0d", i), 16'(b_b), 16'(sat_bin[i]));
            check($sformatf("t3_tc_%0d", i), 16'(tc_b), 16'(sat_tc[i]));
            check($sformatf("t3_gray_%0d", i), 16'(g_b), 16'b1000);
        end
        up_b = 1'b0;
        step();
        check("t3_down_bin", 16'(b_b), 16'd14);
        check("t3_down_tc", 16'(tc_b), 16'd0);
        en_b = 1'b0;

        // 4: load wins over en; outputs hold with en=0
        load_c = 1'b1; lv_c = 8'd5;
        step();
        check("t4_load5", 16'(b_c), 16'd5);
        load_c = 1'b0; en_c = 1'b1; up_c = 1'b1;
        for (int i = 6; i <= 9; i++) begin
            step();
            check($sformatf("t4_up_%0d", i), 16'(b_c), 16'(i));
        end
        load_c = 1'b1; lv_c = 8'd200;
        step();
        // gray(200) = 8'b1010_1100
        check("t4_ld_bin", 16'(b_c), 16'd200);
        check("t4_ld_gray", 16'(g_c), 16'hAC);
        check("t4_ld_tc", 16'(tc_c), 16'd0);
        load_c = 1'b0; en_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t4_hold_bin_%0d", i), 16'(b_c), 16'd200);
            check($sformatf("t4_hold_gray_%0d", i), 16'(g_c), 16'hAC);
            check($sformatf("t4_hold_tc_%0d", i), 16'(tc_c), 16'd0);
        end

        // 5: reset overrides load and en mid-count
        load_c = 1'b1; lv_c = 8'd57;
        step();
        check("t5_at57", 16'(b_c), 16'd57);
        rst_c = 1'b1; en_c = 1'b1; load_c = 1'b1; lv_c = 8'd100;
        step();
        check("t5_rst_bin", 16'(b_c), 16'd3);
        check("t5_rst_gray", 16'(g_c), 16'h02);
        check("t5_rst_tc", 16'(tc_c), 16'd0);
        rst_c = 1'b0; load_c = 1'b0; up_c = 1'b1;
        for (int i = 4; i <= 6; i++) begin
            step();
            check($sformatf("t5_resume_%0d", i), 16'(b_c), 16'(i));
        end
        en_c = 1'b0;

        // 6: direction flips every cycle across the 0/63 boundary
        en_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_d = (i % 2 == 1);
            step();
            check($sformatf("t6_bin_%0d", i), 16'(b_d), (i % 2 == 0) ? 16'd63 : 16'd0);
            check($sformatf("t6_gray_%0d", i), 16'(g_d), (i % 2 == 0) ? 16'h20 : 16'h00);
            check($sformatf("t6_tc_%0d", i), 16'(tc_d), 16'd1);
            check($sformatf("t6_inv_%0d", i), 16'(g_d), 16'(b_d ^ (b_d >> 1)));
        end
        en_d = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
